// File: rtl/rat_path_replayer.sv
// rat_path_replayer: drains the solved rat-maze path from Stack2 one move at a time.
// Each move is replayed from (0,0) and the resulting position goes out on a valid/ready port.
// The block flags a path that steps out of the 16x16 grid or that ends away from (15,15).
//
// Ports:
//   clk, rst       rising-edge clock; synchronous active-low reset
//   start          begin replay (honoured only in IDLE, DONE, ERR)
//   empty2, Move   Stack2 empty flag and top-of-stack direction
//   pop2           Stack2 pop strobe (combinational, LOAD only)
//   out_valid/out_ready/out_move/out_x/out_y   replay step stream
//   move_count     accepted steps, saturating at all-ones
//   busy, done, error   status (done/error are sticky until the next start)
module rat_path_replayer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             empty2,
    input  logic [1:0]       Move,
    output logic             pop2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_move,
    output logic [3:0]       out_x,
    output logic [3:0]       out_y,
    output logic [CNT_W-1:0] move_count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned POS_W   = 4;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(15);

    typedef enum logic [2:0] {IDLE, LOAD, SHOW, DONE, ERR} state_t;

    state_t             state, state_n;
    logic [POS_W-1:0]   pos_x, pos_y, pos_x_n, pos_y_n;
    logic [POS_W-1:0]   nxt_x, nxt_y, nxt_x_n, nxt_y_n;
    logic [POS_W-1:0]   step_x, step_y;
    logic [1:0]         cur_move, cur_move_n;
    logic [CNT_W-1:0]   count_n;
    logic               oob;

    // Candidate position for the stack-top move; oob when the step leaves the grid.
    always_comb begin
        step_x = pos_x;
        step_y = pos_y;
        oob    = 1'b0;
        case (Move)
            2'b00: if (pos_x == '0)     oob = 1'b1; else step_x = pos_x - POS_W'(1);
            2'b01: if (pos_y == POS_MAX) oob = 1'b1; else step_y = pos_y + POS_W'(1);
            2'b10: if (pos_y == '0)     oob = 1'b1; else step_y = pos_y - POS_W'(1);
            default: if (pos_x == POS_MAX) oob = 1'b1; else step_x = pos_x + POS_W'(1);
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        state_n    = state;
        pos_x_n    = pos_x;
        pos_y_n    = pos_y;
        nxt_x_n    = nxt_x;
        nxt_y_n    = nxt_y;
        cur_move_n = cur_move;
        count_n    = move_count;
        pop2       = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    pos_x_n = '0;
                    pos_y_n = '0;
                    count_n = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (empty2) begin
                    state_n = (pos_x == POS_MAX && pos_y == POS_MAX) ? DONE : ERR;
                end else if (oob) begin
                    state_n = ERR;
                end else begin
                    cur_move_n = Move;
                    nxt_x_n    = step_x;
                    nxt_y_n    = step_y;
                    // Gating with rst keeps a reset edge from also consuming a move.
                    pop2       = rst;
                    state_n    = SHOW;
                end
            end
            SHOW: begin
                if (out_ready) begin
                    pos_x_n = nxt_x;
                    pos_y_n = nxt_y;
                    if (move_count != '1) begin
                        count_n = move_count + CNT_W'(1);
                    end
                    state_n = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pos_x      <= '0;
            pos_y      <= '0;
            nxt_x      <= '0;
            nxt_y      <= '0;
            cur_move   <= '0;
            move_count <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            pos_x      <= pos_x_n;
            pos_y      <= pos_y_n;
            nxt_x      <= nxt_x_n;
            nxt_y      <= nxt_y_n;
            cur_move   <= cur_move_n;
            move_count <= count_n;
            out_valid  <= (state_n == SHOW);
            busy       <= (state_n == LOAD) || (state_n == SHOW);
            done       <= (state_n == DONE);
            error      <= (state_n == ERR);
        end
    end

    assign out_move = cur_move;
    assign out_x    = nxt_x;
    assign out_y    = nxt_y;

endmodule

// File: tb/tb_rat_path_replayer.sv
// Directed bench for rat_path_replayer: a Stack2 model feeds moves, handshakes are logged,
// and each scenario task checks its results against hand-computed values.
module tb_rat_path_replayer;

    logic       clk = 1'b0;
    logic       rst, start, out_ready, flush;
    logic       empty2;
    logic [1:0] Move;

    logic       pop2, out_valid, busy, done, error;
    logic [1:0] out_move;
    logic [3:0] out_x, out_y;
    logic [7:0] move_count;

    logic       s_pop2, s_out_valid, s_busy, s_done, s_error;
    logic [1:0] s_out_move;
    logic [3:0] s_out_x, s_out_y;
    logic [1:0] s_move_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0] path [0:511];
    int len  = 0;
    int head = 0;
    int pops = 0;
    logic [1:0] hs_m [0:511];
    logic [3:0] hs_x [0:511];
    logic [3:0] hs_y [0:511];
    int nhs = 0;

    always #5 clk = ~clk;

    rat_path_replayer #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .empty2(empty2), .Move(Move),
        .pop2(pop2), .out_valid(out_valid), .out_ready(out_ready),
        .out_move(out_move), .out_x(out_x), .out_y(out_y),
        .move_count(move_count), .busy(busy), .done(done), .error(error)
    );

    // Narrow-counter copy sharing all inputs, used to observe saturation.
    rat_path_replayer #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .empty2(empty2), .Move(Move),
        .pop2(s_pop2), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_move(s_out_move), .out_x(s_out_x), .out_y(s_out_y),
        .move_count(s_move_count), .busy(s_busy), .done(s_done), .error(s_error)
    );

    // Stack2 model: path[head] is the top; flush discards everything left.
    assign empty2 = (head >= len);
    assign Move   = (head < len) ? path[9'(head)] : 2'b00;

    always @(posedge clk) begin
        if (flush) head <= len;
        else if (pop2) head <= head + 1;
        if (pop2) pops <= pops + 1;
        if (out_valid && out_ready) begin
            hs_m[9'(nhs)] <= out_move;
            hs_x[9'(nhs)] <= out_x;
            hs_y[9'(nhs)] <= out_y;
            nhs <= nhs + 1;
        end
    end

    task automatic push(input logic [1:0] m);
        path[9'(len)] = m;
        len = len + 1;
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    task automatic load_straight();
        for (int i = 0; i < 15; i++) push(2'b11);
        for (int i = 0; i < 15; i++) push(2'b01);
    endtask

    function automatic void exp_straight(input int i, output logic [1:0] m,
                                         output logic [3:0] x, output logic [3:0] y);
        if (i < 15) begin m = 2'b11; x = 4'(i + 1); y = 4'd0; end
        else        begin m = 2'b01; x = 4'd15;     y = 4'(i - 14); end
    endfunction

    // Pulse start, then run until done/error; end_cyc = n where the flag is first seen in cycle k+n.
    // While a step is stalled, the presented step must not change.
    task automatic run_replay(input bit bp, input int budget, output int end_cyc);
        logic [1:0] pm;
        logic [3:0] px, py;
        bit stall;
        int n;
        @(negedge clk); start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        n = 1; end_cyc = -1; stall = 1'b0; pm = '0; px = '0; py = '0;
        while (n <= budget) begin
            if (stall) begin
                n_assert++;
                if (out_valid !== 1'b1 || out_move !== pm || out_x !== px || out_y !== py) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b m=%0d (%0d,%0d) expected v=1 m=%0d (%0d,%0d)",
                             out_valid, out_move, out_x, out_y, pm, px, py);
                end
            end
            if (done === 1'b1 || error === 1'b1) begin
                end_cyc = n;
                break;
            end
            if (bp) out_ready = (n % 3 == 0);
            stall = out_valid && !out_ready;
            pm = out_move; px = out_x; py = out_y;
            @(negedge clk);
            n++;
        end
        n_assert++;
        if (end_cyc < 0) begin
            n_fail++;
            $display("FAIL replay_timeout: got no done/error within %0d cycles expected termination", budget);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_assert++;
        if ({pop2, out_valid, out_move, out_x, out_y, move_count, busy, done, error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pop2=%0b v=%0b m=%0d (%0d,%0d) cnt=%0d busy=%0b done=%0b err=%0b expected all 0",
                     pop2, out_valid, out_move, out_x, out_y, move_count, busy, done, error);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || s_out_valid !== 1'b0 || s_pop2 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: got busy=%0b v=%0b sv=%0b spop=%0b expected 0", busy, out_valid, s_out_valid, s_pop2);
        end
    endtask

    task automatic check_straight_steps(input int h0, input string tag);
        logic [1:0] em;
        logic [3:0] ex, ey;
        for (int i = 0; i < 30; i++) begin
            exp_straight(i, em, ex, ey);
            n_assert++;
            if (hs_m[9'(h0 + i)] !== em || hs_x[9'(h0 + i)] !== ex || hs_y[9'(h0 + i)] !== ey) begin
                n_fail++;
                $display("FAIL %s_step%0d: got m=%0d (%0d,%0d) expected m=%0d (%0d,%0d)", tag, i,
                         hs_m[9'(h0 + i)], hs_x[9'(h0 + i)], hs_y[9'(h0 + i)], em, ex, ey);
            end
        end
    endtask

    task automatic test_straight();
        int p0, h0, ec;
        p0 = pops; h0 = nhs;
        load_straight();
        run_replay(1'b0, 200, ec);
        n_assert++;
        if (ec !== 62) begin n_fail++; $display("FAIL straight_done_cycle: got k+%0d expected k+62", ec); end
        n_assert++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL straight_flags: got done=%0b err=%0b busy=%0b expected 1 0 0", done, error, busy);
        end
        n_assert++;
        if (move_count !== 8'd30) begin n_fail++; $display("FAIL straight_count: got %0d expected 30", move_count); end
        n_assert++;
        if (pops - p0 !== 30 || nhs - h0 !== 30) begin
            n_fail++; $display("FAIL straight_pops: got pops=%0d hs=%0d expected 30 30", pops - p0, nhs - h0);
        end
        n_assert++;
        if (s_move_count !== 2'd3 || s_done !== 1'b1 || s_out_x !== out_x || s_out_move !== out_move) begin
            n_fail++; $display("FAIL saturate_count: got cnt=%0d done=%0b expected 3 1", s_move_count, s_done);
        end
        check_straight_steps(h0, "straight");
    endtask

    task automatic test_backpressure();
        int p0, h0, ec;
        p0 = pops; h0 = nhs;
        load_straight();
        run_replay(1'b1, 400, ec);
        n_assert++;
        if (done !== 1'b1 || error !== 1'b0 || move_count !== 8'd30) begin
            n_fail++; $display("FAIL bp_final: got done=%0b err=%0b cnt=%0d expected 1 0 30", done, error, move_count);
        end
        n_assert++;
        if (pops - p0 !== 30 || nhs - h0 !== 30) begin
            n_fail++; $display("FAIL bp_pops: got pops=%0d hs=%0d expected 30 30", pops - p0, nhs - h0);
        end
        n_assert++;
        if (ec <= 62) begin n_fail++; $display("FAIL bp_slower: got k+%0d expected later than k+62", ec); end
        check_straight_steps(h0, "bp");
    endtask

    task automatic test_oob();
        int p0, ec;
        push(2'b00);
        p0 = pops;
        run_replay(1'b0, 20, ec);
        n_assert++;
        if (ec !== 2 || error !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL oob_error: got k+%0d err=%0b done=%0b expected k+2 1 0", ec, error, done);
        end
        n_assert++;
        if (pops !== p0 || move_count !== 8'd0 || empty2 !== 1'b0 || Move !== 2'b00) begin
            n_fail++; $display("FAIL oob_untouched: got pops=%0d cnt=%0d empty=%0b expected %0d 0 0",
                               pops, move_count, empty2, p0);
        end
        do_flush();
    endtask

    task automatic test_empty();
        int ec;
        run_replay(1'b0, 20, ec);
        n_assert++;
        if (ec !== 2 || error !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL empty_path: got k+%0d err=%0b done=%0b expected k+2 1 0", ec, error, done);
        end
    endtask

    task automatic test_short();
        int p0, h0, ec;
        logic [1:0] em [0:2];
        logic [3:0] ex [0:2];
        logic [3:0] ey [0:2];
        em[0] = 2'b11; ex[0] = 4'd1; ey[0] = 4'd0;
        em[1] = 2'b11; ex[1] = 4'd2; ey[1] = 4'd0;
        em[2] = 2'b01; ex[2] = 4'd2; ey[2] = 4'd1;
        p0 = pops; h0 = nhs;
        for (int i = 0; i < 3; i++) push(em[i]);
        run_replay(1'b0, 40, ec);
        n_assert++;
        if (ec !== 8 || error !== 1'b1 || done !== 1'b0 || move_count !== 8'd3) begin
            n_fail++; $display("FAIL short_path: got k+%0d err=%0b done=%0b cnt=%0d expected k+8 1 0 3",
                               ec, error, done, move_count);
        end
        n_assert++;
        if (pops - p0 !== 3 || nhs - h0 !== 3) begin
            n_fail++; $display("FAIL short_pops: got pops=%0d hs=%0d expected 3 3", pops - p0, nhs - h0);
        end
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (hs_m[9'(h0 + i)] !== em[i] || hs_x[9'(h0 + i)] !== ex[i] || hs_y[9'(h0 + i)] !== ey[i]) begin
                n_fail++;
                $display("FAIL short_step%0d: got m=%0d (%0d,%0d) expected m=%0d (%0d,%0d)", i,
                         hs_m[9'(h0 + i)], hs_x[9'(h0 + i)], hs_y[9'(h0 + i)], em[i], ex[i], ey[i]);
            end
        end
    endtask

    task automatic test_restart();
        int p0, h0, h1, ec, n;
        p0 = pops; h0 = nhs;
        load_straight();
        @(negedge clk); start = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        n_assert++;
        if (out_valid !== 1'b1 || out_move !== 2'b11 || out_x !== 4'd1 || out_y !== 4'd0 || error !== 1'b0) begin
            n_fail++; $display("FAIL first_show: got v=%0b m=%0d (%0d,%0d) err=%0b expected 1 3 (1,0) 0",
                               out_valid, out_move, out_x, out_y, error);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        n_assert++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_x !== 4'd1 || pops - p0 !== 1 || move_count !== 8'd0) begin
            n_fail++; $display("FAIL start_in_show: got v=%0b busy=%0b x=%0d pops=%0d cnt=%0d expected 1 1 1 1 0",
                               out_valid, busy, out_x, pops - p0, move_count);
        end
        out_ready = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        n_assert++;
        if (done !== 1'b1 || move_count !== 8'd30 || nhs - h0 !== 30) begin
            n_fail++; $display("FAIL restart_first_run: got done=%0b cnt=%0d hs=%0d expected 1 30 30",
                               done, move_count, nhs - h0);
        end
        h1 = nhs;
        load_straight();
        run_replay(1'b0, 200, ec);
        n_assert++;
        if (ec !== 62 || done !== 1'b1 || move_count !== 8'd30 || nhs - h1 !== 30) begin
            n_fail++; $display("FAIL restart_second_run: got k+%0d done=%0b cnt=%0d hs=%0d expected k+62 1 30 30",
                               ec, done, move_count, nhs - h1);
        end
        check_straight_steps(h1, "restart");
    endtask

    task automatic test_reset_mid();
        int p0;
        load_straight();
        @(negedge clk); start = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        n_assert++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_show: got v=%0b expected 1", out_valid); end
        p0 = pops;
        rst = 1'b0;
        @(negedge clk);
        n_assert++;
        if ({pop2, out_valid, out_move, out_x, out_y, move_count, busy, done, error} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got pop2=%0b v=%0b m=%0d (%0d,%0d) cnt=%0d busy=%0b expected all 0",
                     pop2, out_valid, out_move, out_x, out_y, move_count, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++;
        if (pops !== p0 || busy !== 1'b0 || out_valid !== 1'b0 || s_busy !== 1'b0 || s_error !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_idle: got pops=%0d busy=%0b v=%0b expected %0d 0 0",
                               pops, busy, out_valid, p0);
        end
        do_flush();
    endtask

    initial begin
        test_reset();
        test_straight();
        test_backpressure();
        test_oob();
        test_empty();
        test_short();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rat_path_replayer.md
# rat_path_replayer

Downstream consumer of the rat-maze datapath's move stack (Stack2). After the solver reaches the goal, this block drains the solved path one move at a time. For each move it tracks the replayed (x, y) position from (0,0) and presents it on a valid/ready output port. It also flags a corrupt path: an out-of-bounds step, or a path that ends away from (15,15).

## Interface
Parameters:
- CNT_W, default 8, width of the replayed-move counter; saturates at all-ones.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets the block).
- start  in  1  one-cycle request to begin replay; sampled only in IDLE, DONE, ERR.
- empty2  in  1  Stack2 empty flag.
- Move  in  2  Stack2 top-of-stack; valid only when empty2==0.
- pop2  out  1  Stack2 pop strobe, exactly one cycle per consumed move.
- out_valid  out  1  replay step available.
- out_ready  in  1  sink accepts the step when out_valid && out_ready.
- out_move  out  2  direction of the current step.
- out_x, out_y  out  4 each  position after applying out_move.
- move_count  out  CNT_W  number of accepted steps.
- busy  out  1  high in LOAD or SHOW.
- done  out  1  path replayed and ended at (15,15).
- error  out  1  path out of bounds or ended short of goal.

## Operation
- Direction encoding, identical to the datapath's Creg:
  - 00: x-1
  - 01: y+1
  - 10: y-1
  - 11: x+1
- Out of bounds means x-1 with x==0, x+1 with x==15, y-1 with y==0, or y+1 with y==15. Arithmetic is 4-bit with no wrap permitted.
- Internal registers: pos_x, pos_y (4b), cur_move (2b), nxt_x, nxt_y, move_count, state.
- States: IDLE, LOAD, SHOW, DONE, ERR.
- IDLE:
  - On start: clear pos to (0,0) and move_count to 0, then go to LOAD.
  - Without start: stay.
- LOAD:
  - If empty2: go to DONE if pos==(15,15), else ERR.
  - Else if Move is out of bounds from pos: go to ERR with no pop.
  - Else: capture Move into cur_move, compute nxt_x/nxt_y, assert pop2 this cycle, go to SHOW.
- SHOW:
  - out_valid=1; out_move=cur_move; out_x/out_y=nxt.
  - On handshake: pos<=nxt, move_count<=move_count+1 (saturating), go to LOAD.
  - Without handshake: hold all outputs stable.
- DONE and ERR:
  - done or error held high (sticky).
  - start restarts exactly as from IDLE (pos cleared, count cleared, flags dropped on entry to LOAD).
- start is ignored in LOAD and SHOW.
- pop2 is decoded as state==LOAD && !empty2 && !oob && rst==1. It is never high outside LOAD.
- Reset mid-operation: at the next edge, state becomes IDLE and all registers clear. No further pop2 is issued. A move already popped is lost, which is acceptable.

## Timing
- Reset values: state=IDLE; pop2=0, out_valid=0, out_move=0, out_x=0, out_y=0, move_count=0, busy=0, done=0, error=0.
- All outputs except pop2 are registered.
- start sampled at edge k → LOAD during cycle k+1 (pop2 high) → out_valid high from cycle k+2.
- Steady-state throughput is one move per 2 cycles when out_ready is held high. The LOAD cycle is never skipped, so Stack2's top settles after each pop before it is sampled again.
- Stack2 pops on the edge ending the LOAD cycle. Move is not sampled again until the next LOAD.
- An empty path (empty2 at first LOAD) → DONE only if (0,0)==(15,15), i.e. never. It therefore goes to ERR in cycle k+2.
- done/error assert the cycle after the terminating LOAD.
- busy drops in the same cycle as done/error asserts.
- move_count at CNT_W all-ones stays at all-ones. Replay continues.

## Test plan
- Reset: hold rst=0 for 2 cycles mid-SHOW with out_valid=1 → next cycle all outputs 0, state IDLE, no pop2 pulse.
- Straight path: Stack2 holds fifteen 11 followed by fifteen 01, out_ready=1, start → 30 handshakes; last step out=(15,15); exactly 30 pop2 pulses; done=1 at cycle k+62; move_count=30; error=0.
- Backpressure: same path with out_ready toggling 1-of-3 cycles → out_move/out_x/out_y stable while out_valid && !out_ready; same 30 steps in order; no extra pops.
- Out of bounds: first move 00 from (0,0) → no pop2, error=1 at k+2, move_count=0, Stack2 contents untouched.
- Short path: stack holds 11,11,01 → three steps ending (2,1), then empty → error=1, done=0, move_count=3.
- Restart and ignore: pulse start during SHOW → no effect. After DONE, reload stack and pulse start → pos restarts at (0,0), done clears, and replay matches the first run.
